// File: rtl/addsub_wb_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : addsub_wb_sequencer
// Purpose  : Wishbone command/result FIFO front end for the 16-bit add/sub stage
// Revision : 1.0 - initial release
// ============================================================================
module addsub_wb_sequencer #(
  parameter int DEPTH         = 4,
  parameter int ADDER_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic [31:0] op_wdata,
  output logic        op_nadd_sub,
  output logic        op_valid,
  input  logic [31:0] res_rdata,
  output logic        busy
);

  localparam int c_AW = $clog2(DEPTH);
  localparam int c_CW = $clog2(DEPTH + 1);
  localparam logic [c_CW-1:0] c_FULL     = c_CW'(DEPTH);
  localparam logic [2:0]      c_LAT_INIT = 3'(ADDER_LATENCY - 1);

  localparam logic [1:0] c_IDLE    = 2'd0;
  localparam logic [1:0] c_ISSUE   = 2'd1;
  localparam logic [1:0] c_WAIT    = 2'd2;
  localparam logic [1:0] c_CAPTURE = 2'd3;

  logic [1:0]      r_state;
  logic [2:0]      r_lat;
  logic            r_ack;
  logic [31:0]     r_dat;
  logic [31:0]     r_op_wdata;
  logic            r_op_sub;
  logic            r_ovf;
  logic            r_udf;

  logic [32:0]     r_cmd_mem [DEPTH];
  logic [c_AW-1:0] r_cmd_wp;
  logic [c_AW-1:0] r_cmd_rp;
  logic [c_CW-1:0] r_cmd_count;

  logic [31:0]     r_res_mem [DEPTH];
  logic [c_AW-1:0] r_res_wp;
  logic [c_AW-1:0] r_res_rp;
  logic [c_CW-1:0] r_res_count;

  logic [1:0]  w_addr;
  logic        w_req;
  logic        w_wr;
  logic        w_rd;
  logic        w_cmd_wr;
  logic        w_cmd_full;
  logic        w_cmd_push;
  logic        w_cmd_pop;
  logic        w_res_empty;
  logic        w_res_pop;
  logic        w_res_push;
  logic        w_clr;
  logic [31:0] w_status;
  logic [31:0] w_rdata;
  logic [29:0] w_unused_adr;

  assign w_unused_adr = {wbs_adr_i[31:4], wbs_adr_i[1:0]};
  assign w_addr       = wbs_adr_i[3:2];
  assign w_req        = wbs_cyc_i & wbs_stb_i & ~r_ack;
  assign w_wr         = w_req & wbs_we_i;
  assign w_rd         = w_req & ~wbs_we_i;

  // Fullness is judged on the pre-pop count, so a push racing an issue still overflows.
  assign w_cmd_wr    = w_wr & ~w_addr[1];
  assign w_cmd_full  = (r_cmd_count == c_FULL);
  assign w_cmd_push  = w_cmd_wr & ~w_cmd_full;
  assign w_cmd_pop   = (r_state == c_ISSUE);
  assign w_res_empty = (r_res_count == '0);
  assign w_res_pop   = w_rd & (w_addr == 2'd2) & ~w_res_empty;
  assign w_res_push  = (r_state == c_CAPTURE);
  assign w_clr       = w_wr & (w_addr == 2'd3);

  assign w_status = {11'd0, w_res_empty, w_cmd_full, r_udf, r_ovf, busy,
                     8'(r_res_count), 8'(r_cmd_count)};

  always_comb begin
    w_rdata = '0;
    if (w_rd) begin
      case (w_addr)
        2'd2:    w_rdata = w_res_empty ? 32'd0 : r_res_mem[r_res_rp];
        2'd3:    w_rdata = w_status;
        default: w_rdata = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_cmd_push) r_cmd_mem[r_cmd_wp] <= {w_addr[0], wbs_dat_i};
    if (w_res_push) r_res_mem[r_res_wp] <= res_rdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ack       <= 1'b0;
      r_dat       <= '0;
      r_ovf       <= 1'b0;
      r_udf       <= 1'b0;
      r_cmd_wp    <= '0;
      r_cmd_rp    <= '0;
      r_cmd_count <= '0;
      r_res_wp    <= '0;
      r_res_rp    <= '0;
      r_res_count <= '0;
    end else begin
      r_ack <= w_req;
      r_dat <= w_rdata;
      if (w_cmd_push) r_cmd_wp <= r_cmd_wp + c_AW'(1);
      if (w_cmd_pop)  r_cmd_rp <= r_cmd_rp + c_AW'(1);
      r_cmd_count <= r_cmd_count + c_CW'(w_cmd_push) - c_CW'(w_cmd_pop);
      if (w_res_push) r_res_wp <= r_res_wp + c_AW'(1);
      if (w_res_pop)  r_res_rp <= r_res_rp + c_AW'(1);
      r_res_count <= r_res_count + c_CW'(w_res_push) - c_CW'(w_res_pop);
      if (w_cmd_wr && w_cmd_full)        r_ovf <= 1'b1;
      else if (w_clr && wbs_dat_i[17])   r_ovf <= 1'b0;
      if (w_rd && (w_addr == 2'd2) && w_res_empty) r_udf <= 1'b1;
      else if (w_clr && wbs_dat_i[18])             r_udf <= 1'b0;
    end
  end

  // Only one command is ever in flight, so checking for result space at issue reserves it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= c_IDLE;
      r_lat      <= '0;
      r_op_wdata <= '0;
      r_op_sub   <= 1'b0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if ((r_cmd_count != '0) && (r_res_count < c_FULL)) begin
            r_state    <= c_ISSUE;
            r_op_wdata <= r_cmd_mem[r_cmd_rp][31:0];
            r_op_sub   <= r_cmd_mem[r_cmd_rp][32];
          end
        end
        c_ISSUE: begin
          r_state <= c_WAIT;
          r_lat   <= c_LAT_INIT;
        end
        c_WAIT: begin
          if (r_lat == 3'd0) r_state <= c_CAPTURE;
          else               r_lat   <= r_lat - 3'd1;
        end
        c_CAPTURE: r_state <= c_IDLE;
        default:   r_state <= c_IDLE;
      endcase
    end
  end

  assign wbs_ack_o   = r_ack;
  assign wbs_dat_o   = r_dat;
  assign op_wdata    = r_op_wdata;
  assign op_nadd_sub = r_op_sub;
  assign op_valid    = (r_state == c_ISSUE);
  assign busy        = (r_state != c_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_addsub_wb_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_addsub_wb_sequencer
// Purpose  : Randomised self-checking bench with a queue-based sequencer model
// Revision : 1.0 - initial release
// ============================================================================
module tb_addsub_wb_sequencer;

  localparam int DEPTH = 4;
  localparam int LAT   = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        wbs_cyc_i, wbs_stb_i, wbs_we_i;
  logic [31:0] wbs_adr_i, wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic [31:0] op_wdata;
  logic        op_nadd_sub;
  logic        op_valid;
  logic [31:0] res_rdata;
  logic        busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  addsub_wb_sequencer #(.DEPTH(DEPTH), .ADDER_LATENCY(LAT)) dut (
    .clk(clk), .reset(reset),
    .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
    .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
    .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
    .op_wdata(op_wdata), .op_nadd_sub(op_nadd_sub), .op_valid(op_valid),
    .res_rdata(res_rdata), .busy(busy)
  );

  function automatic logic [31:0] adder_fn(input logic [31:0] w, input logic sub);
    logic [31:0] x, y;
    x = {16'h0, w[31:16]};
    y = {16'h0, w[15:0]};
    return sub ? (x - y) : (x + y);
  endfunction

  // Adder: the result is present on res_rdata only for the single cycle
  // LAT edges after the issue edge; any other cycle carries junk.
  logic [31:0] a_pipe [0:LAT];
  logic        a_vld  [0:LAT];
  logic [31:0] cyc_n = 32'd0;
  always @(posedge clk) begin
    cyc_n     <= cyc_n + 32'd1;
    a_pipe[0] <= adder_fn(op_wdata, op_nadd_sub);
    a_vld[0]  <= op_valid;
    for (int i = 1; i <= LAT; i++) begin
      a_pipe[i] <= a_pipe[i-1];
      a_vld[i]  <= a_vld[i-1];
    end
  end
  assign res_rdata = a_vld[LAT] ? a_pipe[LAT] : (32'hBAD0_0000 ^ cyc_n);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  // Reference model: queues of commands and results plus sticky flags.
  logic [32:0] m_cmd [$];
  logic [31:0] m_res [$];
  logic        m_ovf, m_udf, m_inflight, m_ack_exp, m_last_sub;
  logic [31:0] m_pend, m_rdata_exp, m_last_wdata;
  int          m_cnt, m_stall;

  function automatic logic [31:0] m_status(input logic b);
    logic [31:0] s;
    s       = '0;
    s[7:0]  = 8'(m_cmd.size());
    s[15:8] = 8'(m_res.size());
    s[16]   = b;
    s[17]   = m_ovf;
    s[18]   = m_udf;
    s[19]   = (m_cmd.size() == DEPTH);
    s[20]   = (m_res.size() == 0);
    return s;
  endfunction

  always @(negedge clk) begin
    logic        req, bexp, legal;
    logic [1:0]  a;
    logic [31:0] rexp;
    logic [32:0] c;
    if (reset) begin
      m_cmd.delete();
      m_res.delete();
      m_ovf = 0; m_udf = 0; m_inflight = 0; m_ack_exp = 0; m_last_sub = 0;
      m_pend = 0; m_rdata_exp = 0; m_last_wdata = 0; m_cnt = 0; m_stall = 0;
    end else begin
      chk("ack", 32'(wbs_ack_o), 32'(m_ack_exp));
      if (m_ack_exp) chk("rdata", wbs_dat_o, m_rdata_exp);
      bexp = m_inflight | op_valid;
      chk("busy", 32'(busy), 32'(bexp));
      legal = (m_cmd.size() > 0) && !m_inflight && (m_res.size() < DEPTH);
      if (op_valid) begin
        chk("issue_legal", 32'(legal), 32'd1);
        if (legal) begin
          chk("op_wdata", op_wdata, m_cmd[0][31:0]);
          chk("op_nadd_sub", 32'(op_nadd_sub), 32'(m_cmd[0][32]));
        end
      end else begin
        chk("op_wdata_hold", op_wdata, m_last_wdata);
        chk("op_nadd_sub_hold", 32'(op_nadd_sub), 32'(m_last_sub));
      end
      if (legal && !op_valid) m_stall++;
      else                    m_stall = 0;
      chk("issue_stall", 32'(m_stall > 1), 32'd0);

      req  = wbs_cyc_i & wbs_stb_i & ~m_ack_exp;
      a    = wbs_adr_i[3:2];
      rexp = '0;
      if (req) begin
        if (wbs_we_i) begin
          if (!a[1]) begin
            if (m_cmd.size() >= DEPTH) m_ovf = 1;
            else                       m_cmd.push_back({a[0], wbs_dat_i});
          end else if (a == 2'd3) begin
            if (wbs_dat_i[17]) m_ovf = 0;
            if (wbs_dat_i[18]) m_udf = 0;
          end
        end else if (a == 2'd2) begin
          if (m_res.size() > 0) rexp = m_res.pop_front();
          else                  m_udf = 1;
        end else if (a == 2'd3) begin
          rexp = m_status(bexp);
        end
      end
      m_ack_exp   = req;
      m_rdata_exp = rexp;
      if (m_inflight) begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_res.push_back(m_pend);
          m_inflight = 0;
        end
      end
      if (op_valid && legal) begin
        c            = m_cmd.pop_front();
        m_pend       = adder_fn(c[31:0], c[32]);
        m_last_wdata = c[31:0];
        m_last_sub   = c[32];
        m_inflight   = 1;
        m_cnt        = LAT + 1;
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wb(input logic we, input logic [1:0] a, input logic [31:0] d,
                    output logic [31:0] rd);
    int n;
    wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = we;
    wbs_adr_i = {28'h0, a, 2'b00}; wbs_dat_i = d;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!wbs_ack_o && n < 8);
    chk("wb_ack_seen", 32'(wbs_ack_o), 32'd1);
    rd = wbs_dat_o;
    wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0;
  endtask

  task automatic wait_op(input string name);
    int n;
    n = 0;
    while (!op_valid && n < 50) begin @(posedge clk); #1; n++; end
    chk(name, 32'(op_valid), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd, d;
    int          n, r;
    reset = 1; wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0;
    wbs_adr_i = '0; wbs_dat_i = '0;
    idle(6);
    reset = 0;

    chk("rst_op_valid", 32'(op_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    wb(0, 2'd3, 0, rd);
    chk("rst_status", rd, 32'h0010_0000);

    wb(1, 2'd0, 32'h0005_0003, rd);
    wait_op("add_issue");
    chk("add_op_wdata", op_wdata, 32'h0005_0003);
    chk("add_op_sub", 32'(op_nadd_sub), 32'd0);
    idle(LAT + 4);
    wb(0, 2'd2, 0, rd);
    chk("add_result", rd, 32'h0000_0008);

    wb(1, 2'd1, 32'h0001_0002, rd);
    wait_op("sub_issue");
    chk("sub_op_sub", 32'(op_nadd_sub), 32'd1);
    idle(LAT + 4);
    wb(0, 2'd2, 0, rd);
    chk("sub_result", rd, 32'hFFFF_FFFF);

    wb(0, 2'd2, 0, rd);
    chk("udf_rdata", rd, 32'h0);
    wb(0, 2'd3, 0, rd);
    chk("udf_status", rd, 32'h0014_0000);
    wb(1, 2'd3, 32'h0004_0000, rd);
    wb(0, 2'd3, 0, rd);
    chk("udf_cleared", rd, 32'h0010_0000);

    // Fill the result FIFO, then overfill the command FIFO while stalled.
    for (int i = 0; i < DEPTH; i++) wb(1, 2'd0, {16'(i + 1), 16'(16 * i)}, rd);
    n = 0;
    do begin wb(0, 2'd3, 0, rd); n++; end while (rd[15:8] != 8'(DEPTH) && n < 100);
    chk("stall_res_full", rd, 32'h0000_0400);
    for (int i = DEPTH; i < 2 * DEPTH + 2; i++) wb(1, 2'd0, {16'(i + 1), 16'(16 * i)}, rd);
    idle(LAT + 4);
    wb(0, 2'd3, 0, rd);
    chk("stall_ovf_status", rd, 32'h000A_0404);
    wb(0, 2'd2, 0, rd);
    chk("stall_first", rd, 32'h0000_0001);
    for (int k = 1; k < 2 * DEPTH; k++) begin
      idle(LAT + 4);
      wb(0, 2'd2, 0, rd);
    end
    chk("stall_last", rd, 32'h0000_0078);
    wb(1, 2'd3, 32'h0002_0000, rd);
    wb(0, 2'd3, 0, rd);
    chk("stall_drained", rd, 32'h0010_0000);

    for (int it = 0; it < 400; it++) begin
      r = int'($urandom_range(0, 9));
      d = $urandom;
      case (r)
        0, 1, 2, 3: wb(1, 2'(r & 1), d, rd);
        4, 5, 6:    wb(0, 2'd2, 0, rd);
        7:          wb(0, 2'd3, 0, rd);
        8:          wb(1, 2'd3, d, rd);
        default: begin
          if (d[0]) wb(0, 2'(d[1]), 0, rd);
          else      wb(1, 2'd2, d, rd);
        end
      endcase
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 6)));
    end
    n = 0;
    while ((m_res.size() > 0 || m_cmd.size() > 0 || m_inflight) && n < 200) begin
      wb(0, 2'd2, 0, rd);
      idle(LAT + 2);
      n++;
    end
    wb(1, 2'd3, 32'h0006_0000, rd);
    wb(0, 2'd3, 0, rd);
    chk("random_drained", rd, 32'h0010_0000);

    // Reset while the adder is mid-flight.
    wb(1, 2'd0, 32'h0007_0001, rd);
    wait_op("rw_issue");
    idle(2);
    reset = 1;
    idle(1);
    reset = 0;
    chk("rw_busy", 32'(busy), 32'd0);
    chk("rw_op_valid", 32'(op_valid), 32'd0);
    wb(0, 2'd3, 0, rd);
    chk("rw_status", rd, 32'h0010_0000);
    idle(LAT + 6);
    wb(0, 2'd3, 0, rd);
    chk("rw_no_late_push", rd, 32'h0010_0000);

    idle(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
